// File: rtl/xm_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xm_mem_arb_pkg
// Brief   : Shared types and defaults for the X-Makina memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package xm_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } grant_e;

  localparam int c_STARVE_LIM_DEF = 4;
  localparam int c_TMO_DEF        = 255;
  localparam int c_WAIT_CNT_W     = 8;

endpackage
`default_nettype wire

// File: rtl/xm_arb_select.sv
`default_nettype none
// ============================================================================
// Module  : xm_arb_select
// Brief   : Fixed CPU-priority winner pick with a DMA starvation streak.
// Revision: 1.0 - initial release
// ============================================================================
module xm_arb_select
  import xm_mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = c_STARVE_LIM_DEF
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic i_cpuReq,
  input  logic i_dmaReq,
  input  logic i_arbEn,
  output logic o_anyReq,
  output logic o_winner
);

  // +2 keeps the width at least one bit even when STARVE_LIM is 0
  localparam int                    c_STREAK_W = $clog2(STARVE_LIM + 2);
  localparam logic [c_STREAK_W-1:0] c_LIM      = c_STREAK_W'(STARVE_LIM);
  localparam logic [c_STREAK_W-1:0] c_ONE      = c_STREAK_W'(1);

  logic [c_STREAK_W-1:0] r_streak;
  grant_e                w_winner;

  always_comb begin
    w_winner = GNT_CPU;
    if (i_dmaReq && (!i_cpuReq || (r_streak == c_LIM))) begin
      w_winner = GNT_DMA;
    end
  end

  assign o_anyReq = i_cpuReq | i_dmaReq;
  assign o_winner = w_winner;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_streak <= '0;
    end else if (i_arbEn) begin
      if (!i_dmaReq || (w_winner == GNT_DMA)) begin
        r_streak <= '0;
      end else if (r_streak != c_LIM) begin
        r_streak <= r_streak + c_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : xm_mem_arbiter
// Brief   : Shares one memory port between CPU and DMA masters with timeout.
// Revision: 1.0 - initial release
// ============================================================================
module xm_mem_arbiter
  import xm_mem_arb_pkg::*;
#(
  parameter int WORD       = 16,
  parameter int STARVE_LIM = c_STARVE_LIM_DEF,
  parameter int TMO        = c_TMO_DEF
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            cpu_req_i,
  input  logic            cpu_rw_i,
  input  logic            cpu_byte_i,
  input  logic [WORD-1:0] cpu_adr_i,
  input  logic [WORD-1:0] cpu_wdata_i,
  output logic            cpu_ack_o,
  output logic            cpu_busy_o,
  input  logic            dma_req_i,
  input  logic            dma_rw_i,
  input  logic            dma_byte_i,
  input  logic [WORD-1:0] dma_adr_i,
  input  logic [WORD-1:0] dma_wdata_i,
  output logic            dma_ack_o,
  output logic            dma_busy_o,
  output logic [WORD-1:0] rdata_o,
  output logic            err_o,
  output logic            mem_en_o,
  output logic            mem_rw_o,
  output logic            mem_byte_o,
  output logic [WORD-1:0] mem_adr_o,
  output logic [WORD-1:0] mem_wdata_o,
  input  logic            mem_busy_i,
  input  logic [WORD-1:0] mem_rdata_i,
  output logic            gnt_o
);

  localparam logic [c_WAIT_CNT_W-1:0] c_TMO_CNT = c_WAIT_CNT_W'(TMO);
  localparam logic [c_WAIT_CNT_W-1:0] c_ONE     = c_WAIT_CNT_W'(1);

  arbState_e               r_state;
  arbState_e               w_nextState;
  grant_e                  r_gnt;
  logic [c_WAIT_CNT_W-1:0] r_waitCnt;
  logic [c_WAIT_CNT_W-1:0] w_waitInc;
  logic                    w_timeout;
  logic                    w_done;
  logic                    w_arbEn;
  logic                    w_anyReq;
  logic                    w_dmaWins;
  logic                    w_selRw;
  logic                    w_selByte;
  logic [WORD-1:0]         w_selAdr;
  logic [WORD-1:0]         w_selWdata;

  logic                    r_memEn;
  logic                    r_memRw;
  logic                    r_memByte;
  logic [WORD-1:0]         r_memAdr;
  logic [WORD-1:0]         r_memWdata;
  logic [WORD-1:0]         r_rdata;
  logic                    r_err;
  logic                    r_cpuAck;
  logic                    r_dmaAck;

  assign w_arbEn = (r_state == IDLE);

  xm_arb_select #(
    .STARVE_LIM (STARVE_LIM)
  ) u_select (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .i_cpuReq (cpu_req_i),
    .i_dmaReq (dma_req_i),
    .i_arbEn  (w_arbEn),
    .o_anyReq (w_anyReq),
    .o_winner (w_dmaWins)
  );

  always_comb begin
    w_nextState = r_state;
    w_waitInc   = r_waitCnt + c_ONE;
    // waitCnt counts completed WAIT cycles, so the abort lands on WAIT cycle TMO
    w_timeout   = (TMO != 0) && (w_waitInc == c_TMO_CNT);
    w_done      = (r_state == WAIT) && (!mem_busy_i || w_timeout);
    w_selRw     = w_dmaWins ? dma_rw_i    : cpu_rw_i;
    w_selByte   = w_dmaWins ? dma_byte_i  : cpu_byte_i;
    w_selAdr    = w_dmaWins ? dma_adr_i   : cpu_adr_i;
    w_selWdata  = w_dmaWins ? dma_wdata_i : cpu_wdata_i;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    if (w_done) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state    <= IDLE;
      r_gnt      <= GNT_CPU;
      r_waitCnt  <= '0;
      r_memEn    <= 1'b0;
      r_memRw    <= 1'b0;
      r_memByte  <= 1'b0;
      r_memAdr   <= '0;
      r_memWdata <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_cpuAck   <= 1'b0;
      r_dmaAck   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_memEn  <= w_arbEn && w_anyReq;
      r_cpuAck <= w_done && (r_gnt == GNT_CPU);
      r_dmaAck <= w_done && (r_gnt == GNT_DMA);
      if (w_arbEn && w_anyReq) begin
        r_gnt      <= grant_e'(w_dmaWins);
        r_memRw    <= w_selRw;
        r_memByte  <= w_selByte;
        r_memAdr   <= w_selAdr;
        r_memWdata <= w_selWdata;
      end
      if (r_state == ISSUE) begin
        r_waitCnt <= '0;
      end
      if (r_state == WAIT) begin
        r_waitCnt <= w_waitInc;
        // read data is captured on writes too; an aborted access keeps the old value
        if (!mem_busy_i) begin
          r_rdata <= mem_rdata_i;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign cpu_ack_o   = r_cpuAck;
  assign dma_ack_o   = r_dmaAck;
  assign cpu_busy_o  = cpu_req_i & ~r_cpuAck;
  assign dma_busy_o  = dma_req_i & ~r_dmaAck;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign mem_en_o    = r_memEn;
  assign mem_rw_o    = r_memRw;
  assign mem_byte_o  = r_memByte;
  assign mem_adr_o   = r_memAdr;
  assign mem_wdata_o = r_memWdata;
  assign gnt_o       = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_xm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_xm_mem_arbiter
// Brief   : Scoreboard bench for xm_mem_arbiter with a small memory responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_xm_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        cpu_req_i, cpu_rw_i, cpu_byte_i;
  logic [15:0] cpu_adr_i, cpu_wdata_i;
  logic        cpu_ack_o, cpu_busy_o;
  logic        dma_req_i, dma_rw_i, dma_byte_i;
  logic [15:0] dma_adr_i, dma_wdata_i;
  logic        dma_ack_o, dma_busy_o;
  logic [15:0] rdata_o;
  logic        err_o, mem_en_o, mem_rw_o, mem_byte_o;
  logic [15:0] mem_adr_o, mem_wdata_o;
  logic        mem_busy_i;
  logic [15:0] mem_rdata_i;
  logic        gnt_o;

  xm_mem_arbiter #(.WORD(16), .STARVE_LIM(4), .TMO(8)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .cpu_req_i(cpu_req_i), .cpu_rw_i(cpu_rw_i), .cpu_byte_i(cpu_byte_i),
    .cpu_adr_i(cpu_adr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_ack_o(cpu_ack_o), .cpu_busy_o(cpu_busy_o),
    .dma_req_i(dma_req_i), .dma_rw_i(dma_rw_i), .dma_byte_i(dma_byte_i),
    .dma_adr_i(dma_adr_i), .dma_wdata_i(dma_wdata_i),
    .dma_ack_o(dma_ack_o), .dma_busy_o(dma_busy_o),
    .rdata_o(rdata_o), .err_o(err_o), .mem_en_o(mem_en_o),
    .mem_rw_o(mem_rw_o), .mem_byte_o(mem_byte_o),
    .mem_adr_o(mem_adr_o), .mem_wdata_o(mem_wdata_o),
    .mem_busy_i(mem_busy_i), .mem_rdata_i(mem_rdata_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  // memory model: busy for busyCycles WAIT cycles after each strobe
  int          busyCycles = 0;
  int          left       = 0;
  logic        stuck      = 1'b0;
  logic        useFixed   = 1'b0;
  logic [15:0] fixedData  = 16'h0000;

  always @(posedge clk_i) begin
    if (mem_en_o) left <= busyCycles;
    else if (left > 0) left <= left - 1;
  end
  assign mem_busy_i  = stuck || (left > 0);
  assign mem_rdata_i = useFixed ? fixedData : (mem_adr_o ^ 16'hA5A5);

  typedef struct packed {
    logic        owner;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        monExp;
  logic [15:0] lastRd = 16'h0000;
  logic        prevEn = 1'b0;
  int          chks   = 0;
  int          errs   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input logic owner, input logic [15:0] rd, input logic err);
    exp_t e;
    e.owner = owner;
    e.err   = err;
    e.rdata = err ? lastRd : rd;
    lastRd  = e.rdata;
    sbQ.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (!arst_i) begin
      prevEn = 1'b0;
    end else begin
      if (mem_en_o) check("mem_en_pulse", 64'(prevEn), 64'd0);
      prevEn = mem_en_o;
      if (cpu_ack_o || dma_ack_o) begin
        check("ack_exclusive", 64'(cpu_ack_o & dma_ack_o), 64'd0);
        if (sbQ.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL unexpected_ack: cpu=%b dma=%b with no access pending", cpu_ack_o, dma_ack_o);
        end else begin
          monExp = sbQ.pop_front();
          check("ack_owner", 64'(dma_ack_o), 64'(monExp.owner));
          check("ack_gnt",   64'(gnt_o),     64'(monExp.owner));
          check("ack_rdata", 64'(rdata_o),   64'(monExp.rdata));
          check("ack_err",   64'(err_o),     64'(monExp.err));
        end
      end
    end
  end

  // waits for the owner's ack; cycle 1 is the ISSUE cycle after the winning IDLE edge
  task automatic waitAck(input logic isDma, input int expLat, input logic chkFld,
                         input logic [33:0] expFld);
    int   n   = 0;
    int   en  = 0;
    logic got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk_i);
      n++;
      if (mem_en_o) en++;
      if (chkFld) check("mem_fields", 64'({mem_rw_o, mem_byte_o, mem_adr_o, mem_wdata_o}), 64'(expFld));
      got = isDma ? dma_ack_o : cpu_ack_o;
    end
    check("ack_seen", 64'(got), 64'd1);
    check("ack_latency", 64'(n), 64'(expLat));
    check("mem_en_count", 64'(en), 64'd1);
    check("busy_at_ack", 64'(isDma ? dma_busy_o : cpu_busy_o), 64'd0);
  endtask

  function automatic logic [54:0] outVec();
    return {mem_en_o, mem_rw_o, mem_byte_o, cpu_ack_o, dma_ack_o, err_o, gnt_o,
            mem_adr_o, mem_wdata_o, rdata_o};
  endfunction

  initial begin
    int acks;
    int n;
    arst_i = 1'b0;
    cpu_req_i = 1'b0; cpu_rw_i = 1'b0; cpu_byte_i = 1'b0; cpu_adr_i = '0; cpu_wdata_i = '0;
    dma_req_i = 1'b0; dma_rw_i = 1'b0; dma_byte_i = 1'b0; dma_adr_i = '0; dma_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_state", 64'(outVec()), 64'd0);
    arst_i = 1'b1;
    @(negedge clk_i);

    // CPU read with two busy WAIT cycles
    useFixed = 1'b1; fixedData = 16'hBEEF; busyCycles = 2;
    cpu_rw_i = 1'b0; cpu_byte_i = 1'b0; cpu_adr_i = 16'h0100; cpu_req_i = 1'b1;
    pushExp(1'b0, 16'hBEEF, 1'b0);
    waitAck(1'b0, 5, 1'b0, '0);
    cpu_req_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // simultaneous requests: CPU first, DMA next
    useFixed = 1'b0; busyCycles = 0;
    cpu_adr_i = 16'h0200; dma_adr_i = 16'h0300; dma_rw_i = 1'b0; dma_byte_i = 1'b0;
    cpu_req_i = 1'b1; dma_req_i = 1'b1;
    pushExp(1'b0, 16'hA7A5, 1'b0);
    pushExp(1'b1, 16'hA6A5, 1'b0);
    waitAck(1'b0, 3, 1'b0, '0);
    cpu_req_i = 1'b0;
    waitAck(1'b1, 4, 1'b0, '0);
    dma_req_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // both held: four CPU grants, then the starvation limit hands one to DMA
    cpu_adr_i = 16'h0400; dma_adr_i = 16'h0500;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) pushExp(1'b1, 16'hA0A5, 1'b0);
      else            pushExp(1'b0, 16'hA1A5, 1'b0);
    end
    cpu_req_i = 1'b1; dma_req_i = 1'b1;
    acks = 0; n = 0;
    while (acks < 10 && n < 300) begin
      @(negedge clk_i);
      n++;
      if (cpu_ack_o || dma_ack_o) acks++;
    end
    cpu_req_i = 1'b0; dma_req_i = 1'b0;
    check("starve_ack_count", 64'(acks), 64'd10);
    repeat (2) @(negedge clk_i);

    // DMA byte write; request fields change after the grant and must not leak through
    busyCycles = 3;
    dma_rw_i = 1'b1; dma_byte_i = 1'b1; dma_adr_i = 16'h2001; dma_wdata_i = 16'h00A5; dma_req_i = 1'b1;
    pushExp(1'b1, 16'h85A4, 1'b0);
    @(posedge clk_i);
    #1;
    dma_adr_i = 16'hFFFF; dma_wdata_i = 16'h1234; dma_byte_i = 1'b0; dma_rw_i = 1'b0;
    waitAck(1'b1, 6, 1'b1, {1'b1, 1'b1, 16'h2001, 16'h00A5});
    dma_req_i = 1'b0;
    repeat (6) @(negedge clk_i);

    // stuck busy: timeout after 8 WAIT cycles, then a clean access
    stuck = 1'b1; busyCycles = 0;
    cpu_rw_i = 1'b0; cpu_adr_i = 16'h0600; cpu_req_i = 1'b1;
    pushExp(1'b0, 16'h0000, 1'b1);
    waitAck(1'b0, 10, 1'b0, '0);
    cpu_req_i = 1'b0; stuck = 1'b0;
    repeat (2) @(negedge clk_i);
    busyCycles = 1; cpu_adr_i = 16'h0700; cpu_req_i = 1'b1;
    pushExp(1'b0, 16'hA2A5, 1'b0);
    waitAck(1'b0, 4, 1'b0, '0);
    cpu_req_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // reset mid-WAIT: outputs clear immediately, the held request restarts
    busyCycles = 5; cpu_adr_i = 16'h0800; cpu_req_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1 arst_i = 1'b0;
    #1 check("async_reset", 64'(outVec()), 64'd0);
    repeat (2) @(negedge clk_i);
    busyCycles = 0;
    lastRd = 16'h0000;
    pushExp(1'b0, 16'hADA5, 1'b0);
    arst_i = 1'b1;
    waitAck(1'b0, 3, 1'b0, '0);
    cpu_req_i = 1'b0;
    repeat (4) @(negedge clk_i);

    check("scoreboard_empty", 64'(sbQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/xm_mem_arbiter.md
Name: xm_mem_arbiter

Overview:
Shares the single X-Makina memory port between two requesters: the CPU control plane and a DMA/debug master. The block sequences each access as a request, a one-cycle memory enable, a wait on memory busy, and a one-cycle acknowledge. The CPU has fixed priority, with a starvation limit that guarantees DMA progress. A wait timeout aborts hung accesses.

Parameters:
WORD, 16, data and address width
STARVE_LIM, 4, consecutive contested CPU grants after which a pending DMA request wins
TMO, 255, maximum WAIT cycles before abort (0 disables timeout); counter width 8 bits

Ports:
clk_i  in  1  clock, rising edge
arst_i  in  1  asynchronous reset, active-low
cpu_req_i  in  1  CPU access request (level)
cpu_rw_i  in  1  CPU direction, 1 = write
cpu_byte_i  in  1  CPU byte access
cpu_adr_i  in  WORD  CPU address
cpu_wdata_i  in  WORD  CPU write data
cpu_ack_o  out  1  CPU access complete (1-cycle pulse)
cpu_busy_o  out  1  cpu_req_i & ~cpu_ack_o
dma_req_i, dma_rw_i, dma_byte_i, dma_adr_i, dma_wdata_i  in  1,1,1,WORD,WORD  DMA equivalents
dma_ack_o, dma_busy_o  out  1,1  DMA equivalents
rdata_o  out  WORD  registered read data; valid when either ack is high
err_o  out  1  timeout flag; valid with ack
mem_en_o  out  1  memory access strobe
mem_rw_o, mem_byte_o  out  1,1  latched direction and size
mem_adr_o, mem_wdata_o  out  WORD,WORD  latched address and write data
mem_busy_i  in  1  memory busy
mem_rdata_i  in  WORD  memory read data
gnt_o  out  1  owner of the current access, 0 = CPU, 1 = DMA

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner. DMA wins if only DMA requests, or if both request and streak == STARVE_LIM. Otherwise CPU wins.
  - At the clock edge, latch the winner's rw, byte, adr and wdata into the mem_* registers, set gnt_o, and go to ISSUE.
- ISSUE: mem_en_o = 1 for exactly one cycle, then go to WAIT. mem_busy_i is ignored in ISSUE.
- WAIT:
  - mem_en_o = 0; latched mem_* fields are held stable.
  - If mem_busy_i = 0: capture mem_rdata_i into rdata_o (for writes too), clear err, go to DONE.
  - Else if TMO != 0 and the wait counter reaches TMO: set err, go to DONE. rdata_o is unchanged.
- DONE: the owner's ack_o = 1 and err_o = err for one cycle, then go to IDLE.
- Requester rules:
  - A requester must drop req_i in the cycle after ack_o. If req_i is still high in IDLE, it is treated as a new access.
  - req_i changes while the requester is not the owner are legal.
  - Request fields are sampled only at the IDLE edge where the requester wins.
- Minimum access time is 4 cycles (IDLE→DONE) with mem_busy_i already low in WAIT.
- streak counter:
  - Increments on a CPU grant made while dma_req_i = 1, saturating at STARVE_LIM.
  - Clears on any DMA grant, or at IDLE when dma_req_i = 0.
- Wait counter: cleared on entering WAIT, increments each WAIT cycle.
- Reset (any time, including mid-WAIT):
  - State = IDLE.
  - mem_en_o, mem_rw_o, mem_byte_o, acks, err_o, gnt_o = 0.
  - mem_adr_o, mem_wdata_o, rdata_o = 0.
  - Both counters = 0.
  - No ack is issued for the aborted access; the requester re-requests.
- Both ack_o never high together. Outputs are registered except busy_o.

Decomposition:
- Shared package xm_mem_arb_pkg:
  - State enum (IDLE/ISSUE/WAIT/DONE).
  - Grant enum (GNT_CPU = 0, GNT_DMA = 1).
  - Default STARVE_LIM and TMO constants.
- One sub-module, xm_arb_select: combinational winner pick from req bits and streak, plus registered streak update.

Test Plan:
- CPU read, adr 0x0100; mem_busy_i high for 2 WAIT cycles and mem_rdata_i = 0xBEEF → mem_en_o high 1 cycle; cpu_ack_o in cycle 6 after req; rdata_o = 0xBEEF; err_o = 0.
- CPU and DMA request in the same cycle → gnt_o = 0, CPU served first; DMA (still requesting) is granted in the following IDLE.
- CPU req held continuously (re-requesting after each ack) with DMA req held → 4 CPU acks, then 1 DMA ack, then the CPU resumes; pattern repeats.
- DMA byte write, adr 0x2001, wdata 0x00A5 → mem_rw_o = 1, mem_byte_o = 1, mem_adr_o = 0x2001 stable through WAIT; dma_ack_o pulses once.
- TMO = 8, mem_busy_i stuck high → ack with err_o = 1 after 8 WAIT cycles; the next access completes normally with err_o = 0.
- arst_i low during WAIT → all outputs 0 asynchronously, no ack; after release, the pending CPU req restarts from ISSUE.
